// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and types for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int REG_W_DFLT   = 5;
    localparam int MDU_LAT_DFLT = 4;
    localparam int ZERO_REG     = 0;

    // Debug encoding of the highest-priority stall reason this cycle
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_BRANCH   = 2'd2,
        HZ_MDU      = 2'd3
    } hazard_cause_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline-to-scoreboard hazard signal bundle
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = REG_W_DFLT
) ();

    logic [REG_W-1:0] rsD;
    logic [REG_W-1:0] rtD;
    logic             useRsD;
    logic             useRtD;
    logic             branchD;
    logic             regWriteD;
    logic [REG_W-1:0] writeRegD;
    logic             mduOpD;
    logic             regWriteE;
    logic             memToRegE;
    logic [REG_W-1:0] writeRegisterE;
    logic             memToRegM;
    logic [REG_W-1:0] writeRegisterM;
    logic             mduStartE;
    logic [REG_W-1:0] mduDestE;

    logic             stallF;
    logic             stallD;
    logic             flushE;
    logic             mduBusy;
    logic             mduDone;
    logic [REG_W-1:0] mduDestW;
    logic             mduOverrun;
    hazard_cause_e    hazardCause;

    // Pipeline side: presents stage information, receives stall controls
    modport master (
        output rsD, rtD, useRsD, useRtD, branchD, regWriteD, writeRegD, mduOpD,
               regWriteE, memToRegE, writeRegisterE, memToRegM, writeRegisterM,
               mduStartE, mduDestE,
        input  stallF, stallD, flushE, mduBusy, mduDone, mduDestW, mduOverrun,
               hazardCause
    );

    // Scoreboard side
    modport slave (
        input  rsD, rtD, useRsD, useRtD, branchD, regWriteD, writeRegD, mduOpD,
               regWriteE, memToRegE, writeRegisterE, memToRegM, writeRegisterM,
               mduStartE, mduDestE,
        output stallF, stallD, flushE, mduBusy, mduDone, mduDestW, mduOverrun,
               hazardCause
    );

endinterface

// File: rtl/hazard_scoreboard_mdu_tracker.sv
// rtl/hazard_scoreboard_mdu_tracker.sv - tracks the single outstanding MDU op
module mdu_tracker
    import hazard_scoreboard_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DFLT,
    parameter int REG_W   = REG_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REG_W-1:0] destIn,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] dest,
    output logic             overrun
);

    // Counter must hold MDU_LAT-1; keep at least one bit when MDU_LAT is 1
    localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    mdu_state_e       state;
    mdu_state_e       stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [REG_W-1:0] destNext;

    // State, counter, destination and sticky overrun registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MDU_IDLE;
            cnt     <= '0;
            dest    <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            dest    <= destNext;
            // An issue attempt while an op is outstanding is dropped and flagged
            overrun <= overrun | (start & (state == MDU_BUSY));
        end
    end

    // Next-state: load on issue from IDLE, count down while BUSY, release at zero
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        destNext  = dest;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    stateNext = MDU_BUSY;
                    cntNext   = CNT_LOAD;
                    destNext  = destIn;
                end
            end
            MDU_BUSY: begin
                if (cnt == '0) begin
                    stateNext = MDU_IDLE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: begin
                stateNext = MDU_IDLE;
            end
        endcase
    end

    // Outputs: busy for the whole op, done on its final cycle
    always_comb begin
        busy = (state == MDU_BUSY);
        done = (state == MDU_BUSY) && (cnt == '0);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use, branch and MDU hazard stall/flush control
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DFLT,
    parameter int REG_W   = REG_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave hz
);

    logic             mduBusy;
    logic             mduDone;
    logic [REG_W-1:0] mduDest;
    logic             mduOverrun;
    logic             lwStall;
    logic             branchStall;
    logic             mduStall;

    // r0 is hardwired, so a match on it never creates a dependency
    function automatic logic regHit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != REG_W'(ZERO_REG)) && (a == b);
    endfunction

    mdu_tracker #(
        .MDU_LAT (MDU_LAT),
        .REG_W   (REG_W)
    ) uTracker (
        .clk     (clk),
        .rst     (rst),
        .start   (hz.mduStartE),
        .destIn  (hz.mduDestE),
        .busy    (mduBusy),
        .done    (mduDone),
        .dest    (mduDest),
        .overrun (mduOverrun)
    );

    // Hazard detection: loads in E, branch operands not yet forwardable, MDU in flight
    always_comb begin
        lwStall = hz.memToRegE &
                  ((hz.useRsD & regHit(hz.rsD, hz.writeRegisterE)) |
                   (hz.useRtD & regHit(hz.rtD, hz.writeRegisterE)));

        branchStall = hz.branchD &
                      ((hz.regWriteE & (regHit(hz.writeRegisterE, hz.rsD) |
                                        regHit(hz.writeRegisterE, hz.rtD))) |
                       (hz.memToRegM & (regHit(hz.writeRegisterM, hz.rsD) |
                                        regHit(hz.writeRegisterM, hz.rtD))));

        // writeRegD term prevents WAW reordering; mduOpD is the one-op structural limit
        mduStall = mduBusy &
                   ((hz.useRsD & regHit(hz.rsD, mduDest)) |
                    (hz.useRtD & regHit(hz.rtD, mduDest)) |
                    (hz.regWriteD & regHit(hz.writeRegD, mduDest)) |
                    hz.mduOpD);
    end

    // Drive pipeline controls and the debug cause
    always_comb begin
        hz.stallF     = lwStall | branchStall | mduStall;
        hz.stallD     = lwStall | branchStall | mduStall;
        hz.flushE     = lwStall | branchStall | mduStall;
        hz.mduBusy    = mduBusy;
        hz.mduDone    = mduDone;
        hz.mduDestW   = mduDest;
        hz.mduOverrun = mduOverrun;
        if (lwStall) begin
            hz.hazardCause = HZ_LOAD_USE;
        end else if (branchStall) begin
            hz.hazardCause = HZ_BRANCH;
        end else if (mduStall) begin
            hz.hazardCause = HZ_MDU;
        end else begin
            hz.hazardCause = HZ_NONE;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench with directed and random stimulus
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int LAT = 4;
    localparam int RW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_scoreboard_if #(.REG_W(RW)) hz ();

    hazard_scoreboard #(
        .MDU_LAT (LAT),
        .REG_W   (RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [RW-1:0] rsD;
        logic [RW-1:0] rtD;
        logic          useRsD;
        logic          useRtD;
        logic          branchD;
        logic          regWriteD;
        logic [RW-1:0] writeRegD;
        logic          mduOpD;
        logic          regWriteE;
        logic          memToRegE;
        logic [RW-1:0] writeRegisterE;
        logic          memToRegM;
        logic [RW-1:0] writeRegisterM;
        logic          mduStartE;
        logic [RW-1:0] mduDestE;
    } stim_t;

    typedef struct {
        int            cyc;
        logic          stall;
        logic          busy;
        logic          done;
        logic [RW-1:0] dest;
        logic          overrun;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: one op, described by its issue cycle and destination
    bit            mInFlight = 1'b0;
    int            mIssue    = 0;
    logic [RW-1:0] mDest     = '0;
    bit            mOverrun  = 1'b0;

    function automatic bit hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 1'b0; s.rsD = '0; s.rtD = '0; s.useRsD = 1'b0; s.useRtD = 1'b0;
        s.branchD = 1'b0; s.regWriteD = 1'b0; s.writeRegD = '0; s.mduOpD = 1'b0;
        s.regWriteE = 1'b0; s.memToRegE = 1'b0; s.writeRegisterE = '0;
        s.memToRegM = 1'b0; s.writeRegisterM = '0; s.mduStartE = 1'b0; s.mduDestE = '0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   busy;
        bit   lw;
        bit   br;
        bit   md;
        rst                = s.rst;
        hz.rsD             = s.rsD;
        hz.rtD             = s.rtD;
        hz.useRsD          = s.useRsD;
        hz.useRtD          = s.useRtD;
        hz.branchD         = s.branchD;
        hz.regWriteD       = s.regWriteD;
        hz.writeRegD       = s.writeRegD;
        hz.mduOpD          = s.mduOpD;
        hz.regWriteE       = s.regWriteE;
        hz.memToRegE       = s.memToRegE;
        hz.writeRegisterE  = s.writeRegisterE;
        hz.memToRegM       = s.memToRegM;
        hz.writeRegisterM  = s.writeRegisterM;
        hz.mduStartE       = s.mduStartE;
        hz.mduDestE        = s.mduDestE;

        busy = mInFlight && (cyc > mIssue) && (cyc <= mIssue + LAT);
        lw = s.memToRegE && ((s.useRsD && hit(s.rsD, s.writeRegisterE)) ||
                             (s.useRtD && hit(s.rtD, s.writeRegisterE)));
        br = s.branchD && ((s.regWriteE && (hit(s.writeRegisterE, s.rsD) || hit(s.writeRegisterE, s.rtD))) ||
                           (s.memToRegM && (hit(s.writeRegisterM, s.rsD) || hit(s.writeRegisterM, s.rtD))));
        md = busy && ((s.useRsD && hit(s.rsD, mDest)) || (s.useRtD && hit(s.rtD, mDest)) ||
                      (s.regWriteD && hit(s.writeRegD, mDest)) || s.mduOpD);

        e.cyc     = cyc;
        e.stall   = lw || br || md;
        e.busy    = busy;
        e.done    = busy && (cyc == mIssue + LAT);
        e.dest    = mDest;
        e.overrun = mOverrun;
        expQ.push_back(e);

        if (s.rst) begin
            mInFlight = 1'b0;
            mDest     = '0;
            mOverrun  = 1'b0;
        end else if (s.mduStartE) begin
            if (busy) begin
                mOverrun = 1'b1;
            end else begin
                mInFlight = 1'b1;
                mIssue    = cyc;
                mDest     = s.mduDestE;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("stallF", e.cyc, 32'(hz.stallF), 32'(e.stall));
                check("stallD", e.cyc, 32'(hz.stallD), 32'(e.stall));
                check("flushE", e.cyc, 32'(hz.flushE), 32'(e.stall));
                check("mduBusy", e.cyc, 32'(hz.mduBusy), 32'(e.busy));
                check("mduDone", e.cyc, 32'(hz.mduDone), 32'(e.done));
                check("mduDestW", e.cyc, 32'(hz.mduDestW), 32'(e.dest));
                check("mduOverrun", e.cyc, 32'(hz.mduOverrun), 32'(e.overrun));
            end
        end
    end

    initial begin
        stim_t s;
        s = idleStim();
        hz.rsD = '0; hz.rtD = '0; hz.useRsD = 1'b0; hz.useRtD = 1'b0; hz.branchD = 1'b0;
        hz.regWriteD = 1'b0; hz.writeRegD = '0; hz.mduOpD = 1'b0; hz.regWriteE = 1'b0;
        hz.memToRegE = 1'b0; hz.writeRegisterE = '0; hz.memToRegM = 1'b0;
        hz.writeRegisterM = '0; hz.mduStartE = 1'b0; hz.mduDestE = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        drive(idleStim());
        drive(idleStim());

        s = idleStim(); s.memToRegE = 1'b1; s.writeRegisterE = 5; s.rsD = 5; s.useRsD = 1'b1;
        drive(s);
        s.rsD = 0; s.writeRegisterE = 0;
        drive(s);

        s = idleStim(); s.branchD = 1'b1; s.regWriteE = 1'b1; s.writeRegisterE = 7; s.rtD = 7;
        drive(s);
        s = idleStim(); s.branchD = 1'b1; s.memToRegM = 1'b1; s.writeRegisterM = 7; s.rtD = 7;
        drive(s);
        drive(idleStim());

        s = idleStim(); s.mduStartE = 1'b1; s.mduDestE = 9;
        drive(s);
        s = idleStim(); s.useRsD = 1'b1; s.rsD = 9;
        drive(s);
        s = idleStim(); s.mduOpD = 1'b1; s.mduStartE = 1'b1; s.mduDestE = 4;
        drive(s);
        s = idleStim(); s.regWriteD = 1'b1; s.writeRegD = 9;
        drive(s);
        s = idleStim(); s.useRsD = 1'b1; s.rsD = 3;
        drive(s);
        s = idleStim(); s.useRsD = 1'b1; s.rsD = 9;
        drive(s);
        drive(idleStim());

        s = idleStim(); s.mduStartE = 1'b1; s.mduDestE = 9;
        drive(s);
        s = idleStim(); s.useRsD = 1'b1; s.rsD = 9;
        drive(s);
        s.rst = 1'b1;
        drive(s);
        s.rst = 1'b0;
        drive(s);
        drive(idleStim());

        for (int i = 0; i < 3000; i++) begin
            s.rst            = ($urandom_range(0, 49) == 0);
            s.rsD            = RW'($urandom_range(0, 3));
            s.rtD            = RW'($urandom_range(0, 3));
            s.useRsD         = 1'($urandom_range(0, 1));
            s.useRtD         = 1'($urandom_range(0, 1));
            s.branchD        = ($urandom_range(0, 3) == 0);
            s.regWriteD      = 1'($urandom_range(0, 1));
            s.writeRegD      = RW'($urandom_range(0, 3));
            s.mduOpD         = ($urandom_range(0, 5) == 0);
            s.regWriteE      = 1'($urandom_range(0, 1));
            s.memToRegE      = ($urandom_range(0, 3) == 0);
            s.writeRegisterE = RW'($urandom_range(0, 3));
            s.memToRegM      = ($urandom_range(0, 3) == 0);
            s.writeRegisterM = RW'($urandom_range(0, 3));
            s.mduStartE      = ($urandom_range(0, 5) == 0);
            s.mduDestE       = RW'($urandom_range(0, 3));
            drive(s);
        end
        drive(idleStim());

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side hazard controller for the pipelined core. It tracks the in-flight destination register of the iterative multiply/divide unit (MDU) and detects load-use and decode-stage branch hazards that forwarding cannot cover. It drives the stall and flush controls for the F, D and E stages. It sits beside the forwarding unit: the forwarding unit consumes completed results, and this block withholds instructions until those results exist.

## Interface

Parameters:
- MDU_LAT, 4: cycles from MDU issue to result; must be ≥1.
- REG_W, 5: register index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- rsD, rtD  in  REG_W  source registers of the instruction in D.
- useRsD, useRtD  in  1  D instruction actually reads rs/rt.
- branchD  in  1  D instruction is a branch resolved in D.
- regWriteD  in  1  D instruction writes a register.
- writeRegD  in  REG_W  D destination register.
- mduOpD  in  1  D instruction is an MDU operation.
- regWriteE, memToRegE  in  1  E-stage write / load flags.
- writeRegisterE  in  REG_W  E destination register.
- memToRegM  in  1  M-stage load flag.
- writeRegisterM  in  REG_W  M destination register.
- mduStartE  in  1  MDU op in E is issuing this cycle.
- mduDestE  in  REG_W  destination register of the issuing MDU op.
- stallF, stallD  out  1  hold PC and the F/D register.
- flushE  out  1  insert a bubble into the D/E register.
- mduBusy  out  1  MDU op outstanding.
- mduDone  out  1  one-cycle pulse: MDU result valid this cycle.
- mduDestW  out  REG_W  destination register of the outstanding/completing MDU op.
- mduOverrun  out  1  sticky error flag.

## Operation

- Register 0 never creates a hazard. Every match term requires its register index to be non-zero.
- lwStall = memToRegE & ((useRsD & rsD==writeRegisterE) | (useRtD & rtD==writeRegisterE)).
- branchStall = branchD & ((regWriteE & writeRegisterE∈{rsD,rtD}) | (memToRegM & writeRegisterM∈{rsD,rtD})).
- mduStall = mduBusy & ((useRsD & rsD==mduDestW) | (useRtD & rtD==mduDestW) | (regWriteD & writeRegD==mduDestW) | mduOpD).
  - The writeRegD term covers WAW.
  - The mduOpD term is the structural hazard: only one MDU op may be outstanding.
- stallD = stallF = flushE = lwStall | branchStall | mduStall.
- Scoreboard state machine:
  - States are IDLE (busy=0) and BUSY (busy=1).
  - Registers: down-counter cnt, dest.
  - IDLE with mduStartE: go to BUSY; cnt ← MDU_LAT−1; dest ← mduDestE.
  - BUSY with cnt≠0: cnt decrements each cycle.
  - BUSY with cnt==0: mduDone=1 (combinational); return to IDLE the next cycle.
- mduStartE while BUSY is an illegal issue. The start is ignored, state is unchanged, and mduOverrun sets. mduOverrun stays set until rst.
- mduDestE==0 is accepted and times normally, but never produces a register match.
- mduDestW = dest in all states. It holds its last value in IDLE.

## Timing

- Stall, flush and match outputs are combinational from the inputs and current state, with no added latency.
- Issue at cycle t (mduStartE=1, IDLE):
  - mduBusy=1 from t+1 through t+MDU_LAT.
  - mduDone=1 at cycle t+MDU_LAT only.
  - IDLE at t+MDU_LAT+1.
- mduStall stays asserted through the mduDone cycle. A dependent instruction leaves D at t+MDU_LAT+1, by which point the register file holds the result.
- Back-to-back MDU ops: the second op issues no earlier than t+MDU_LAT+2.
- Reset values: busy=0, cnt=0, dest=0, mduOverrun=0, mduDone=0, mduBusy=0.
  - With all inputs low, every output is 0.
- rst during BUSY abandons the operation. No mduDone is produced.
- rst has priority over a simultaneous mduStartE.

## Structure

- Shared pipeline package holds:
  - REG_W and the zero-register constant.
  - The hazard-cause encoding for debug (none/load-use/branch/MDU).
- The counter and dest register form one natural sub-module, mdu_tracker: start/done/busy/dest. The stall equations stay in the top level.

## Test plan

- Load-use: memToRegE=1, writeRegisterE=5, rsD=5, useRsD=1 -> stallF=stallD=flushE=1. Same stimulus with rsD=0 and writeRegisterE=0 -> all 0.
- Branch: branchD=1, regWriteE=1, writeRegisterE=7, rtD=7 -> stall for one cycle. memToRegM=1, writeRegisterM=7 -> stall.
- MDU latency with MDU_LAT=4: mduStartE with mduDestE=9 at cycle 10 -> mduBusy=1 for cycles 11–14, mduDone=1 at cycle 14 only, mduDestW=9. D reading r9 is stalled for cycles 11–14 and released at 15.
- Structural/WAW: while BUSY, mduOpD=1 -> stall. regWriteD=1 with writeRegD=9 -> stall. Unrelated rsD=3 -> no stall.
- Overrun: mduStartE with mduDestE=4 while BUSY -> dest stays 9, mduOverrun=1 and holds until rst.
- Reset mid-op: rst at cycle 12 of the above run -> cycle 13 shows mduBusy=0, no mduDone, mduOverrun=0, all stalls 0.
